// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, per-bit oversample/bit counters,
// byte assembly, parity/stop checking and frame-end status pulses.
module uart_rx_ctrl #(
    parameter int PRESCALER_WIDTH = 5,
    parameter int DATA_WIDTH      = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       rx_in,
    input  logic [PRESCALER_WIDTH-1:0] prescale,
    input  logic                       par_en,
    input  logic                       par_typ,
    input  logic                       sampled_bit,
    output logic                       dat_samp_en,
    output logic [3:0]                 edge_cnt,
    output logic [DATA_WIDTH-1:0]      p_data,
    output logic                       data_valid,
    output logic                       par_err,
    output logic                       stp_err,
    output logic                       strt_glitch,
    output logic                       busy
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            edge_q, edge_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  p8_q, p8_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_bad_q, par_bad_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  glitch_q, glitch_d;
    logic [3:0]            last_edge;
    logic                  decide;

    // Only 8 is special; every other prescale value runs as 16.
    assign last_edge = p8_q ? 4'd7 : 4'd15;
    assign decide    = (edge_q == last_edge);

    always_comb begin
        state_d      = state_q;
        edge_d       = edge_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        p8_d         = p8_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_bad_d    = par_bad_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        glitch_d     = 1'b0;

        if (state_q == IDLE) edge_d = 4'd0;
        else                 edge_d = decide ? 4'd0 : edge_q + 4'd1;

        case (state_q)
            IDLE: begin
                if (!rx_in) begin
                    state_d   = START;
                    p8_d      = (prescale == PRESCALER_WIDTH'(8));
                    par_en_d  = par_en;
                    par_typ_d = par_typ;
                    par_bad_d = 1'b0;
                end
            end
            START: begin
                if (decide) begin
                    if (sampled_bit) begin
                        glitch_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
            end
            DATA: begin
                if (decide) begin
                    shift_d[bit_q] = sampled_bit;
                    bit_d          = bit_q + BW'(1);
                    if (bit_q == BW'(DATA_WIDTH - 1))
                        state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (decide) begin
                    par_bad_d = sampled_bit ^ (^shift_q) ^ par_typ_q;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    // Status is registered, so it appears the cycle after this decision.
                    par_err_d = par_bad_q;
                    stp_err_d = ~sampled_bit;
                    if (!par_bad_q && sampled_bit) begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            edge_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            p8_q         <= 1'b0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            glitch_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_q       <= edge_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            p8_q         <= p8_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_bad_q    <= par_bad_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            glitch_q     <= glitch_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign dat_samp_en = busy;
    assign edge_cnt    = edge_q;
    assign p_data      = p_data_q;
    assign data_valid  = data_valid_q;
    assign par_err     = par_err_q;
    assign stp_err     = stp_err_q;
    assign strt_glitch = glitch_q;

endmodule
